// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out bus for conv_window_gen.
//   master : pixel source + window consumer side (drives Clear, Data_In, Valid_in)
//   slave  : the window generator (drives Window_Out, Valid_Out, Frame_Last)
//   Clear      sync frame restart
//   Data_In    pixel, channel 0 in LSBs
//   Valid_in   Data_In valid
//   Window_Out KSIZE*KSIZE pixels, element (r*KSIZE+c) at [(r*KSIZE+c)*PIX_W +: PIX_W]
//   Valid_Out  one-cycle new-window strobe
//   Frame_Last last window of the frame
//   Out_Row/Out_Col (WINDOW_COORD_EN only) top-left input coordinate of the window
interface conv_window_gen_if #(
  parameter int PIX_W = 8,
  parameter int KSIZE = 3
);
  logic                           Clear;
  logic [PIX_W-1:0]               Data_In;
  logic                           Valid_in;
  logic [KSIZE*KSIZE*PIX_W-1:0]   Window_Out;
  logic                           Valid_Out;
  logic                           Frame_Last;
`ifdef WINDOW_COORD_EN
  logic [15:0]                    Out_Row;
  logic [15:0]                    Out_Col;
`endif

  modport master (
    output Clear, Data_In, Valid_in,
    input  Window_Out, Valid_Out, Frame_Last
`ifdef WINDOW_COORD_EN
    , input Out_Row, Out_Col
`endif
  );

  modport slave (
    input  Clear, Data_In, Valid_in,
    output Window_Out, Valid_Out, Frame_Last
`ifdef WINDOW_COORD_EN
    , output Out_Row, Out_Col
`endif
  );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: KSIZE x KSIZE sliding-window generator over a raster pixel stream.
// Buffers KSIZE-1 lines, keeps a KSIZE x KSIZE shift-register window and emits a
// registered copy of it for every window position on the STRIDE grid.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  conv_window_gen_if.slave (Clear, Data_In, Valid_in in; Window_Out,
//        Valid_Out, Frame_Last out)
// Optional feature macro: WINDOW_COORD_EN adds Out_Row/Out_Col (top-left coordinate).
module conv_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int KSIZE      = 3,
  parameter int STRIDE     = 1
) (
  input  logic             clk,
  input  logic             rst,
  conv_window_gen_if.slave bus
);
  localparam int PIX_W    = DATA_WIDTH * CHANNELS;
  localparam int WIN_W    = KSIZE * KSIZE * PIX_W;
  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int RW       = $clog2(IMG_HEIGHT);
  localparam int PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  // Completing-pixel coordinate of the last window on the stride grid.
  localparam int COL_LAST = KSIZE - 1 + ((IMG_WIDTH - KSIZE) / STRIDE) * STRIDE;
  localparam int ROW_LAST = KSIZE - 1 + ((IMG_HEIGHT - KSIZE) / STRIDE) * STRIDE;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] cph_q, cph_d;   // (col-KSIZE+1) % STRIDE once col >= KSIZE-1
  logic [PW-1:0] rph_q, rph_d;   // (row-KSIZE+1) % STRIDE once row >= KSIZE-1

  logic accept, col_end, row_end, win_pos, fire, last_pos;

  assign accept   = bus.Valid_in & ~bus.Clear;
  assign col_end  = (col_q == CW'(IMG_WIDTH - 1));
  assign row_end  = (row_q == RW'(IMG_HEIGHT - 1));
  assign win_pos  = (col_q >= CW'(KSIZE - 1)) && (row_q >= RW'(KSIZE - 1)) &&
                    (cph_q == '0) && (rph_q == '0);
  assign fire     = accept & win_pos;
  assign last_pos = (col_q == CW'(COL_LAST)) && (row_q == RW'(ROW_LAST));

  // Position counters and stride phases
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (bus.Clear) begin
      col_d = '0;
      row_d = '0;
      cph_d = '0;
      rph_d = '0;
    end else if (bus.Valid_in) begin
      if (col_end) begin
        col_d = '0;
        cph_d = '0;
        if (row_end) begin
          row_d = '0;
          rph_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          // phase starts counting only once the row is a valid window bottom
          if (row_q >= RW'(KSIZE - 1))
            rph_d = (rph_q == PW'(STRIDE - 1)) ? '0 : rph_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
        if (col_q >= CW'(KSIZE - 1))
          cph_d = (cph_q == PW'(STRIDE - 1)) ? '0 : cph_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      cph_q <= '0;
      rph_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cph_q <= cph_d;
      rph_q <= rph_d;
    end
  end

  // Storage: lb_q[KSIZE-2] is the previous line, lb_q[0] the oldest.
  logic [PIX_W-1:0] lb_q    [KSIZE-1][IMG_WIDTH];
  logic [PIX_W-1:0] tap     [KSIZE];
  logic [PIX_W-1:0] win_q   [KSIZE][KSIZE];
  logic [PIX_W-1:0] win_nxt [KSIZE][KSIZE];
  logic [WIN_W-1:0] win_flat;

  always_comb begin
    for (int k = 0; k < KSIZE - 1; k++) tap[k] = lb_q[k][col_q];
    tap[KSIZE-1] = bus.Data_In;
  end

  // Window shifts left by one column; the new right column is this column's taps.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) win_nxt[r][c] = win_q[r][c+1];
      win_nxt[r][KSIZE-1] = tap[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        win_flat[(r*KSIZE+c)*PIX_W +: PIX_W] = win_nxt[r][c];
  end

  // Line buffers and the window array are not reset; the validity rule never
  // lets stale lines or columns reach the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < KSIZE - 2; k++) lb_q[k][col_q] <= lb_q[k+1][col_q];
      lb_q[KSIZE-2][col_q] <= bus.Data_In;
      win_q <= win_nxt;
    end
  end

  // Output register: captured on the edge that accepts the completing pixel.
  logic [WIN_W-1:0] wout_q;
  logic             vout_q, flast_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wout_q  <= '0;
      vout_q  <= 1'b0;
      flast_q <= 1'b0;
    end else begin
      vout_q  <= fire;
      flast_q <= fire & last_pos;
      if (fire) wout_q <= win_flat;
    end
  end

  assign bus.Window_Out = wout_q;
  assign bus.Valid_Out  = vout_q;
  assign bus.Frame_Last = flast_q;

`ifdef WINDOW_COORD_EN
  logic [15:0] orow_q, ocol_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      orow_q <= '0;
      ocol_q <= '0;
    end else if (fire) begin
      orow_q <= 16'(row_q) - 16'(KSIZE - 1);
      ocol_q <= 16'(col_q) - 16'(KSIZE - 1);
    end
  end

  assign bus.Out_Row = orow_q;
  assign bus.Out_Col = ocol_q;
`endif
endmodule
